rmon_ctrl: RTL and testbench
============================

RMON_CTRL -- requirements
Module: RMON_ctrl

Interface
REQ-001 SHALL take parameter INIT_CLEAR, default 1, meaning: 1 = zero all 64 counter entries after reset, 0 = skip the clear sweep.
REQ-002 SHALL have port Clk  in  1  single clock for all logic.
REQ-003 SHALL have port Reset  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port Reg_apply_0  in  1  Rx update request, held high until Reg_next_0.
REQ-005 SHALL have port Reg_addr_0  in  5  Rx counter index.
REQ-006 SHALL have port Reg_data_0  in  16  Rx increment value.
REQ-007 SHALL have port Reg_next_0  out  1  Rx grant/done pulse.
REQ-008 SHALL have ports Reg_apply_1 (in, 1), Reg_addr_1 (in, 5), Reg_data_1 (in, 16) and Reg_next_1 (out, 1) for Tx, with the same meanings as the Rx ports.
REQ-009 SHALL have port CPU_clr_apply  in  1  CPU clear request, held high until CPU_clr_ack.
REQ-010 SHALL have port CPU_clr_addr  in  6  entry to zero.
REQ-011 SHALL have port CPU_clr_ack  out  1  clear done pulse.
REQ-012 SHALL have port Addra  out  6  RAM port-A address.
REQ-013 SHALL have port Dina  out  32  RAM port-A write data.
REQ-014 SHALL have port Wea  out  1  RAM port-A write enable.
REQ-015 SHALL have port Douta  in  32  RAM port-A read data, valid the cycle after Addra is sampled.
REQ-016 SHALL have port Init_busy  out  1  high while the clear sweep runs.

Function
REQ-017 SHALL implement states INIT, IDLE, RD, ADD, WR, CLR.
REQ-018 INIT SHALL write Dina=0 with Wea=1 to Addra=0..63, one entry per cycle (64 cycles), then go to IDLE; with INIT_CLEAR=0, Reset SHALL lead directly to IDLE.
REQ-019 IDLE SHALL sample requests; CPU_clr_apply SHALL have strict priority; Rx and Tx SHALL be served round-robin.
REQ-020 The round-robin pointer SHALL favour Rx after reset and SHALL toggle to the other requester after each Rx/Tx grant.
REQ-021 A CPU clear SHALL take one CLR cycle: Addra=CPU_clr_addr, Dina=0, Wea=1, CPU_clr_ack=1; the next state SHALL be IDLE.
REQ-022 On an Rx/Tx grant, the controller SHALL latch the selected index and data, where Addra={0,Reg_addr_0} for Rx and {1,Reg_addr_1} for Tx.
REQ-023 RD SHALL drive Addra with Wea=0.
REQ-024 ADD SHALL register sum = Douta + zero-extended data, modulo 2^32 (wrap, no saturation).
REQ-025 WR SHALL drive the same Addra with Dina=sum and Wea=1, and SHALL pulse Reg_next_x for exactly that cycle; the next state SHALL be IDLE.
REQ-026 One Rx/Tx update SHALL take 4 cycles (IDLE->RD->ADD->WR); Addra SHALL be held stable through RD..WR.
REQ-027 Requests SHALL be sampled only in IDLE; a request arriving in another state SHALL wait without loss.
REQ-028 Requesters SHALL drop apply in the cycle after Reg_next_x/CPU_clr_ack; an apply still high in IDLE SHALL count as a new request.
REQ-029 Wea SHALL be 0 in IDLE, RD and ADD.
REQ-030 Reg_next_0, Reg_next_1 and CPU_clr_ack SHALL be mutually exclusive and never high outside WR/CLR.
REQ-031 Requests during INIT SHALL be held off; Init_busy SHALL be 1 exactly during the INIT cycles.

Reset
REQ-032 Reset SHALL act on the clock edge and, when high, SHALL force state=INIT (IDLE if INIT_CLEAR=0), sweep counter=0, RR pointer=Rx, Wea=0, Addra=0, Dina=0, all acks=0, and Init_busy=INIT_CLEAR.
REQ-033 Reset asserted mid-update SHALL abort the update without a write or ack; the aborted request SHALL be re-served only if still applied after reset.

Verification
REQ-034 Reset, then idle -> 64 writes of 0 to addresses 0..63 on consecutive cycles, Init_busy high for 64 cycles, then IDLE.
REQ-035 Entry 5 holds 0x10, then Rx apply with addr 5, data 0x0040 -> Reg_next_0 on the 4th cycle and entry 5 holds 0x50.
REQ-036 Rx (addr 1) and Tx (addr 1) applied together after reset -> Rx served first (entry 1), Tx next (entry 33), two Reg_next pulses 4 cycles apart.
REQ-037 Entry 40 holds 0xFFFFFFF0, then Tx apply with addr 8, data 0x0020 -> entry 40 = 0x00000010.
REQ-038 CPU_clr_apply (addr 7) and Rx apply in the same IDLE cycle -> CLR first (entry 7=0, ack one cycle), then the Rx update.
REQ-039 Reset pulsed during ADD -> no Wea during the aborted update, no Reg_next, INIT sweep restarts at address 0.

Source files
------------

// File: rtl/rmon_ctrl.sv
// -----------------------------------------------------------------------------
// rmon_ctrl -- statistics counter update controller
//
// Owns port A of a 64 x 32-bit counter RAM and serialises three clients onto it:
//   * Rx updater  (entries 0..31)  : read-add-write of a 16-bit increment
//   * Tx updater  (entries 32..63) : read-add-write of a 16-bit increment
//   * CPU clear                    : single-cycle write of zero to any entry
// After reset an optional sweep zeroes all 64 entries before any client is
// served.
//
// Ports
//   Clk            in   clock for all logic
//   Reset          in   synchronous, active-high reset
//   Reg_apply_0    in   Rx request, held until Reg_next_0
//   Reg_addr_0     in   Rx counter index (0..31)
//   Reg_data_0     in   Rx increment
//   Reg_next_0     out  Rx done pulse (the write cycle)
//   Reg_apply_1    in   Tx request, held until Reg_next_1
//   Reg_addr_1     in   Tx counter index (maps to 32..63)
//   Reg_data_1     in   Tx increment
//   Reg_next_1     out  Tx done pulse (the write cycle)
//   CPU_clr_apply  in   CPU clear request, held until CPU_clr_ack
//   CPU_clr_addr   in   entry to zero
//   CPU_clr_ack    out  clear done pulse (the write cycle)
//   Addra          out  RAM port-A address
//   Dina           out  RAM port-A write data
//   Wea            out  RAM port-A write enable
//   Douta          in   RAM port-A read data, one cycle after Addra
//   Init_busy      out  high while the clear sweep runs
// -----------------------------------------------------------------------------
module rmon_ctrl #(
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Reg_apply_0,
    input  logic [4:0]  Reg_addr_0,
    input  logic [15:0] Reg_data_0,
    output logic        Reg_next_0,
    input  logic        Reg_apply_1,
    input  logic [4:0]  Reg_addr_1,
    input  logic [15:0] Reg_data_1,
    output logic        Reg_next_1,
    input  logic        CPU_clr_apply,
    input  logic [5:0]  CPU_clr_addr,
    output logic        CPU_clr_ack,
    output logic [5:0]  Addra,
    output logic [31:0] Dina,
    output logic        Wea,
    input  logic [31:0] Douta,
    output logic        Init_busy
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD,
        ST_ADD,
        ST_WR,
        ST_CLR
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q,   cnt_d;    // sweep address
    logic        rr_q,    rr_d;     // 1: Tx has priority on the next tie
    logic        src_q,   src_d;    // 1: the update in flight belongs to Tx
    logic [5:0]  addr_q,  addr_d;   // entry being updated or cleared
    logic [15:0] data_q,  data_d;   // increment being applied
    logic [31:0] sum_q,   sum_d;    // read value plus increment

    logic grant_tx;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of every other one.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= INIT_CLEAR ? ST_INIT : ST_IDLE;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            src_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            src_q   <= src_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sum_q   <= sum_d;
        end
    end

    // Next-state logic. Requests are only looked at in IDLE, so a client
    // that raises apply at any other time simply waits with apply held.
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        src_d    = src_q;
        addr_d   = addr_q;
        data_d   = data_q;
        sum_d    = sum_q;
        grant_tx = 1'b0;

        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (CPU_clr_apply) begin
                    addr_d  = CPU_clr_addr;
                    state_d = ST_CLR;
                end else if (Reg_apply_0 || Reg_apply_1) begin
                    // Tx wins when it is the only requester or when it holds
                    // the round-robin token; the token then passes to the
                    // requester that was not served.
                    grant_tx = Reg_apply_1 && (!Reg_apply_0 || rr_q);
                    src_d    = grant_tx;
                    rr_d     = !grant_tx;
                    addr_d   = grant_tx ? {1'b1, Reg_addr_1} : {1'b0, Reg_addr_0};
                    data_d   = grant_tx ? Reg_data_1 : Reg_data_0;
                    state_d  = ST_RD;
                end
            end
            ST_RD: begin
                state_d = ST_ADD;
            end
            ST_ADD: begin
                // Counters wrap silently at 2^32.
                sum_d   = Douta + {16'h0000, data_q};
                state_d = ST_WR;
            end
            ST_WR: begin
                state_d = ST_IDLE;
            end
            ST_CLR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM port and handshake outputs are decoded from the current state.
    // They are held at zero while Reset is high so an update interrupted by
    // reset can never issue its write or its done pulse.
    always_comb begin
        Addra       = '0;
        Dina        = '0;
        Wea         = 1'b0;
        Reg_next_0  = 1'b0;
        Reg_next_1  = 1'b0;
        CPU_clr_ack = 1'b0;

        if (!Reset) begin
            case (state_q)
                ST_INIT: begin
                    Addra = cnt_q;
                    Wea   = 1'b1;
                end
                ST_RD, ST_ADD: begin
                    Addra = addr_q;
                end
                ST_WR: begin
                    Addra      = addr_q;
                    Dina       = sum_q;
                    Wea        = 1'b1;
                    Reg_next_0 = !src_q;
                    Reg_next_1 = src_q;
                end
                ST_CLR: begin
                    Addra       = addr_q;
                    Wea         = 1'b1;
                    CPU_clr_ack = 1'b1;
                end
                default: begin
                    Addra = '0;
                end
            endcase
        end
    end

    assign Init_busy = Reset ? INIT_CLEAR : (state_q == ST_INIT);

endmodule

// File: tb/tb_rmon_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rmon_ctrl -- self-checking bench for rmon_ctrl
//
// A behavioural 64 x 32 RAM hangs off port A. Every write the controller is
// expected to make (address, data and which done pulse accompanies it) is
// queued when the stimulus is issued; a negedge monitor pops and compares one
// entry per observed write. Scenario tasks add their own latency and RAM
// content checks.
// -----------------------------------------------------------------------------
module tb_rmon_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Reg_apply_0, Reg_apply_1, CPU_clr_apply;
    logic [4:0]  Reg_addr_0, Reg_addr_1;
    logic [15:0] Reg_data_0, Reg_data_1;
    logic [5:0]  CPU_clr_addr;
    logic        Reg_next_0, Reg_next_1, CPU_clr_ack;
    logic [5:0]  Addra;
    logic [31:0] Dina;
    logic        Wea;
    logic [31:0] Douta;
    logic        Init_busy;

    always #5 Clk = ~Clk;

    rmon_ctrl #(.INIT_CLEAR(1'b1)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Reg_apply_0   (Reg_apply_0),
        .Reg_addr_0    (Reg_addr_0),
        .Reg_data_0    (Reg_data_0),
        .Reg_next_0    (Reg_next_0),
        .Reg_apply_1   (Reg_apply_1),
        .Reg_addr_1    (Reg_addr_1),
        .Reg_data_1    (Reg_data_1),
        .Reg_next_1    (Reg_next_1),
        .CPU_clr_apply (CPU_clr_apply),
        .CPU_clr_addr  (CPU_clr_addr),
        .CPU_clr_ack   (CPU_clr_ack),
        .Addra         (Addra),
        .Dina          (Dina),
        .Wea           (Wea),
        .Douta         (Douta),
        .Init_busy     (Init_busy)
    );

    // Counter RAM with a backdoor preload port used only while the DUT idles.
    logic [31:0] ram [64];
    logic        bd_we = 1'b0;
    logic [5:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    always @(posedge Clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (Wea === 1'b1) ram[Addra] <= Dina;
        Douta <= ram[Addra];
    end

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // kind: 0 = plain write, 1 = Rx done, 2 = Tx done, 3 = clear done
    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        int          kind;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] shadow [64];
    bit          favour_tx = 1'b0;
    int          compared = 0;
    int          mismatched = 0;
    bit          mon_en = 1'b0;

    exp_t mon_e;
    int   mon_acks;
    int   mon_kind;

    always @(negedge Clk) begin
        if (mon_en) begin
            mon_acks = int'(Reg_next_0 === 1'b1) + int'(Reg_next_1 === 1'b1) + int'(CPU_clr_ack === 1'b1);
            if (mon_acks != 0) begin
                compared++;
                if (mon_acks > 1 || Wea !== 1'b1) begin
                    mismatched++;
                    $display("FAIL ack_exclusive: next0=%b next1=%b clr_ack=%b wea=%b, expected one ack with wea=1",
                             Reg_next_0, Reg_next_1, CPU_clr_ack, Wea);
                end
            end
            if (Wea === 1'b1) begin
                compared++;
                mon_kind = (Reg_next_0 === 1'b1) ? 1 : (Reg_next_1 === 1'b1) ? 2 : (CPU_clr_ack === 1'b1) ? 3 : 0;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_write: addr=%0d data=%h kind=%0d, expected no write", Addra, Dina, mon_kind);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (Addra !== mon_e.addr || Dina !== mon_e.data || mon_kind != mon_e.kind) begin
                        mismatched++;
                        $display("FAIL write: got addr=%0d data=%h kind=%0d, expected addr=%0d data=%h kind=%0d",
                                 Addra, Dina, mon_kind, mon_e.addr, mon_e.data, mon_e.kind);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_add(input int kind, input logic [5:0] a, input logic [15:0] d);
        shadow[a] = shadow[a] + {16'h0000, d};
        exp_q.push_back('{addr: a, data: shadow[a], kind: kind});
    endtask

    task automatic push_clear(input int kind, input logic [5:0] a);
        shadow[a] = '0;
        exp_q.push_back('{addr: a, data: 32'h0, kind: kind});
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] v);
        bd_addr = a;
        bd_data = v;
        bd_we   = 1'b1;
        tick();
        bd_we   = 1'b0;
        shadow[a] = v;
    endtask

    task automatic wait_drain(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
    endtask

    // who: 0 = Rx, 1 = Tx, 2 = CPU clear. Holds apply until the done pulse,
    // then drops it in the following cycle.
    task automatic serve(input int who, input logic [5:0] a, input logic [15:0] d,
                         input int max_cyc, output int ack_cyc, output bit ok);
        ok = 1'b0;
        ack_cyc = -1;
        case (who)
            0: begin Reg_addr_0 = a[4:0]; Reg_data_0 = d; Reg_apply_0 = 1'b1; end
            1: begin Reg_addr_1 = a[4:0]; Reg_data_1 = d; Reg_apply_1 = 1'b1; end
            default: begin CPU_clr_addr = a; CPU_clr_apply = 1'b1; end
        endcase
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge Clk);
            if ((who == 0 && Reg_next_0 === 1'b1) || (who == 1 && Reg_next_1 === 1'b1) ||
                (who == 2 && CPU_clr_ack === 1'b1)) begin
                ok = 1'b1;
                ack_cyc = cyc;
                break;
            end
        end
        tick();
        case (who)
            0: Reg_apply_0 = 1'b0;
            1: Reg_apply_1 = 1'b0;
            default: CPU_clr_apply = 1'b0;
        endcase
    endtask

    task automatic test_reset();
        int n;
        bit ok;
        Reset = 1'b1;
        Reg_apply_0 = 1'b0; Reg_apply_1 = 1'b0; CPU_clr_apply = 1'b0;
        Reg_addr_0 = '0; Reg_addr_1 = '0; Reg_data_0 = '0; Reg_data_1 = '0; CPU_clr_addr = '0;
        for (int i = 0; i < 64; i++) push_clear(0, 6'(i));
        tick();
        tick();
        @(negedge Clk);
        compared++;
        if (Wea !== 1'b0 || Addra !== 6'd0 || Dina !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_port: wea=%b addra=%0d dina=%h, expected 0/0/0", Wea, Addra, Dina);
        end
        compared++;
        if ({Reg_next_0, Reg_next_1, CPU_clr_ack} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_acks: got %b, expected 000", {Reg_next_0, Reg_next_1, CPU_clr_ack});
        end
        compared++;
        if (Init_busy !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_init_busy: got %b, expected 1", Init_busy);
        end
        mon_en = 1'b1;
        tick();
        Reset = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (Init_busy !== 1'b1) break;
            n++;
        end
        compared++;
        if (n != 64) begin
            mismatched++;
            $display("FAIL init_busy_len: got %0d cycles, expected 64", n);
        end
        wait_drain(10, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL init_sweep: %0d writes outstanding, expected 0", exp_q.size());
        end
        tick();
        compared++;
        if (ram[0] !== 32'h0 || ram[63] !== 32'h0) begin
            mismatched++;
            $display("FAIL init_ram: ram[0]=%h ram[63]=%h, expected 0", ram[0], ram[63]);
        end
        favour_tx = 1'b0;
    endtask

    task automatic test_rr_after_reset();
        int start, c0, c1;
        bit ok0, ok1;
        push_add(1, 6'd1, 16'h0011);
        push_add(2, 6'd33, 16'h0022);
        start = cyc;
        fork
            serve(0, 6'd1, 16'h0011, 40, c0, ok0);
            serve(1, 6'd1, 16'h0022, 40, c1, ok1);
        join
        compared++;
        if (!ok0 || !ok1) begin
            mismatched++;
            $display("FAIL rr_timeout: rx_done=%b tx_done=%b, expected 1/1", ok0, ok1);
        end
        compared++;
        if (c0 - start != 3 || c1 - c0 != 4) begin
            mismatched++;
            $display("FAIL rr_timing: rx at +%0d tx at +%0d, expected +3 and +7", c0 - start, c1 - start);
        end
        tick();
        compared++;
        if (ram[1] !== 32'h11 || ram[33] !== 32'h22) begin
            mismatched++;
            $display("FAIL rr_ram: ram[1]=%h ram[33]=%h, expected 11/22", ram[1], ram[33]);
        end
        favour_tx = 1'b0;
    endtask

    task automatic test_rx_update();
        int start, c;
        bit ok;
        preload(6'd5, 32'h10);
        push_add(1, 6'd5, 16'h0040);
        start = cyc;
        serve(0, 6'd5, 16'h0040, 40, c, ok);
        compared++;
        if (!ok || c - start != 3) begin
            mismatched++;
            $display("FAIL rx_latency: done=%b at +%0d, expected done at +3", ok, c - start);
        end
        tick();
        compared++;
        if (ram[5] !== 32'h50) begin
            mismatched++;
            $display("FAIL rx_sum: ram[5]=%h, expected 00000050", ram[5]);
        end
        favour_tx = 1'b1;
    endtask

    task automatic test_wrap();
        int c;
        bit ok;
        preload(6'd40, 32'hFFFF_FFF0);
        push_add(2, 6'd40, 16'h0020);
        serve(1, 6'd8, 16'h0020, 40, c, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL wrap_timeout: done=%b, expected 1", ok);
        end
        tick();
        compared++;
        if (ram[40] !== 32'h0000_0010) begin
            mismatched++;
            $display("FAIL wrap_sum: ram[40]=%h, expected 00000010", ram[40]);
        end
        favour_tx = 1'b0;
    endtask

    task automatic test_clr_priority();
        int start, cc, cr;
        bit okc, okr;
        preload(6'd7, 32'h1234);
        push_clear(3, 6'd7);
        push_add(1, 6'd7, 16'h0003);
        start = cyc;
        fork
            serve(2, 6'd7, 16'h0000, 40, cc, okc);
            serve(0, 6'd7, 16'h0003, 40, cr, okr);
        join
        compared++;
        if (!okc || !okr || cc - start != 1 || cr - start != 5) begin
            mismatched++;
            $display("FAIL clr_priority: clr %b at +%0d rx %b at +%0d, expected clr at +1 then rx at +5",
                     okc, cc - start, okr, cr - start);
        end
        tick();
        compared++;
        if (ram[7] !== 32'h3) begin
            mismatched++;
            $display("FAIL clr_then_rx: ram[7]=%h, expected 00000003", ram[7]);
        end
        favour_tx = 1'b1;
    endtask

    task automatic test_back_to_back();
        int modes [6];
        logic [4:0]  ra, ta;
        logic [15:0] rd, td;
        int ca, ct, diff;
        bit oka, okt, ok;
        int bad;
        modes = '{2, 0, 2, 1, 2, 2};
        for (int it = 0; it < 6; it++) begin
            ra = 5'($urandom_range(0, 31));
            ta = 5'($urandom_range(0, 31));
            rd = 16'($urandom);
            td = 16'($urandom);
            oka = 1'b1; okt = 1'b1; ca = 0; ct = 0;
            if (modes[it] == 0) begin
                push_add(1, {1'b0, ra}, rd);
                serve(0, {1'b0, ra}, rd, 40, ca, oka);
                favour_tx = 1'b1;
            end else if (modes[it] == 1) begin
                push_add(2, {1'b1, ta}, td);
                serve(1, {1'b1, ta}, td, 40, ct, okt);
                favour_tx = 1'b0;
            end else begin
                if (!favour_tx) begin
                    push_add(1, {1'b0, ra}, rd);
                    push_add(2, {1'b1, ta}, td);
                end else begin
                    push_add(2, {1'b1, ta}, td);
                    push_add(1, {1'b0, ra}, rd);
                end
                fork
                    serve(0, {1'b0, ra}, rd, 40, ca, oka);
                    serve(1, {1'b1, ta}, td, 40, ct, okt);
                join
                diff = favour_tx ? (ca - ct) : (ct - ca);
                compared++;
                if (diff != 4) begin
                    mismatched++;
                    $display("FAIL b2b_order[%0d]: second done %0d cycles after first, expected 4 (favour_tx=%b)",
                             it, diff, favour_tx);
                end
            end
            compared++;
            if (!oka || !okt) begin
                mismatched++;
                $display("FAIL b2b_timeout[%0d]: rx=%b tx=%b, expected 1/1", it, oka, okt);
            end
        end
        wait_drain(10, ok);
        tick();
        bad = 0;
        for (int i = 0; i < 64; i++) if (ram[i] !== shadow[i]) bad++;
        compared++;
        if (!ok || bad != 0) begin
            mismatched++;
            $display("FAIL b2b_ram: %0d entries differ, drained=%b, expected 0 and 1", bad, ok);
        end
    endtask

    task automatic test_reset_mid_update();
        int start, c, n;
        bit ok, okd;
        for (int i = 0; i < 64; i++) push_clear(0, 6'(i));
        push_add(1, 6'd3, 16'h0077);
        n = 0;
        start = cyc;
        fork
            serve(0, 6'd3, 16'h0077, 300, c, ok);
            begin
                tick();
                tick();
                Reset = 1'b1;
                @(negedge Clk);
                compared++;
                if (Wea !== 1'b0 || Reg_next_0 !== 1'b0) begin
                    mismatched++;
                    $display("FAIL abort_outputs: wea=%b next0=%b, expected 0/0", Wea, Reg_next_0);
                end
                tick();
                Reset = 1'b0;
                for (int i = 0; i < 200; i++) begin
                    @(negedge Clk);
                    if (Init_busy !== 1'b1) break;
                    n++;
                end
            end
        join
        favour_tx = 1'b1;
        compared++;
        if (n != 64) begin
            mismatched++;
            $display("FAIL abort_init_len: got %0d cycles, expected 64", n);
        end
        compared++;
        if (!ok || c - start != 70) begin
            mismatched++;
            $display("FAIL abort_reserve: done=%b at +%0d, expected done at +70", ok, c - start);
        end
        wait_drain(10, okd);
        tick();
        compared++;
        if (!okd || ram[3] !== 32'h77 || ram[0] !== 32'h0) begin
            mismatched++;
            $display("FAIL abort_ram: drained=%b ram[3]=%h ram[0]=%h, expected 1/00000077/00000000",
                     okd, ram[3], ram[0]);
        end
    endtask

    initial begin
        test_reset();
        test_rr_after_reset();
        test_rx_update();
        test_wrap();
        test_clr_priority();
        test_back_to_back();
        test_reset_mid_update();
        repeat (3) tick();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL leftover_writes: %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
